// File: rtl/pc_ctrl.sv
// pc_ctrl: decodes instructions and ALU flags into program-counter write/branch/stall controls
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   instr_valid/instr new instruction word (opcode [15:12], target/offset [7:0])
//   flag_we/alu_z/n   flag register load strobe and ALU zero/negative results
//   resume            leave HALTED
//   pcWR/ifBan        one-cycle absolute-load / relative-add pulses to the PC
//   jump              target or offset, held until the next taken transfer
//   stop/halted       PC freeze and HALTED status
//   flush             upstream fetch discards its instruction while high
//   taken_cnt         saturating count of taken transfers
module pc_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    input  logic              flag_we,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              resume,
    output logic              pcWR,
    output logic              ifBan,
    output logic [ADDR_W-1:0] jump,
    output logic              stop,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_cnt
);
    typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

    state_t            state_q, state_d;
    logic [2:0]        fcnt_q, fcnt_d;
    logic              pcwr_q, pcwr_d, ifban_q, ifban_d, stop_q, stop_d, flush_q, flush_d;
    logic [ADDR_W-1:0] jump_q, jump_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              z_q, z_d, n_q, n_d;
    logic              z_eff, n_eff, go, is_jmp, is_br, take;
    logic [3:0]        op;

    always_comb begin
        // a branch decoded alongside a flag write sees the incoming flags
        z_eff   = flag_we ? alu_z : z_q;
        n_eff   = flag_we ? alu_n : n_q;
        op      = instr[15:12];
        is_jmp  = op == 4'h1;
        is_br   = (op == 4'h2 && z_eff) || (op == 4'h3 && !z_eff) || (op == 4'h4 && n_eff);
        go      = state_q == RUN && instr_valid;
        take    = go && (is_jmp || is_br);
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pcwr_d  = 1'b0;
        ifban_d = 1'b0;
        jump_d  = jump_q;
        stop_d  = stop_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        z_d     = z_eff;
        n_d     = n_eff;
        if (take) begin
            pcwr_d  = is_jmp;
            ifban_d = !is_jmp;
            jump_d  = ADDR_W'(instr[7:0]);
            flush_d = 1'b1;
            fcnt_d  = 3'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end else if (go && op == 4'hF) begin
            stop_d  = 1'b1;
            state_d = HALTED;
        end else if (state_q == FLUSH) begin
            // fcnt counts the flush cycles still to come after this one
            fcnt_d  = fcnt_q == 3'd0 ? fcnt_q : fcnt_q - 3'd1;
            flush_d = fcnt_q != 3'd0;
            state_d = fcnt_q == 3'd0 ? RUN : FLUSH;
        end else if (state_q == HALTED && resume) begin
            stop_d  = 1'b0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            pcwr_q  <= 1'b0;
            ifban_q <= 1'b0;
            jump_q  <= '0;
            stop_q  <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pcwr_q  <= pcwr_d;
            ifban_q <= ifban_d;
            jump_q  <= jump_d;
            stop_q  <= stop_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign pcWR      = pcwr_q;
    assign ifBan     = ifban_q;
    assign jump      = jump_q;
    assign stop      = stop_q;
    assign flush     = flush_q;
    assign halted    = state_q == HALTED;
    assign taken_cnt = cnt_q;
endmodule
